mul_fu_ctrl: RTL and testbench
==============================

Name: mul_fu_ctrl

Overview:
Multiply functional-unit controller for the out-of-order core's RV32M MUL/MULH/MULHSU/MULHU path. It accepts one issued op from the multiply reservation station and converts signed operands to magnitudes. It drives the unsigned pipelined 32x32 multiplier (dadda_multiplier_32), which has no valid signal and needs its operands held stable for MUL_LATENCY cycles. It then re-applies the sign, selects the result half, and holds the result on the CDB until granted.

Parameters:
MUL_LATENCY, 14, cycles from operands first presented to mult_p valid (dadda_multiplier_32 depth)
ROB_IDX_W, 5, ROB index width
PREG_W, 6, physical register tag width

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high; clock clk
flush  input  1  pipeline flush (branch mispredict), synchronous
issue_valid  input  1  RS presents op
issue_ready  output  1  unit accepts op this cycle
issue_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
issue_rs1_v  input  32  operand A
issue_rs2_v  input  32  operand B
issue_rob_idx  input  ROB_IDX_W  ROB tag
issue_pd  input  PREG_W  destination physical reg
mult_a  output  32  magnitude A to multiplier (registered)
mult_b  output  32  magnitude B to multiplier (registered)
mult_p  input  64  unsigned product from multiplier
cdb_valid  output  1  result request/valid
cdb_ready  input  1  CDB grant
cdb_rob_idx  output  ROB_IDX_W  echoed tag
cdb_pd  output  PREG_W  echoed dest
cdb_data  output  32  result

Behaviour:
- States: IDLE, BUSY, DONE. Counter cnt, width $clog2(MUL_LATENCY+1).
- Reset: state IDLE, cnt 0, mult_a/mult_b 0, cdb_valid 0, cdb_rob_idx/cdb_pd/cdb_data 0. issue_ready 0 while rst is high. Reset mid-op aborts with no CDB output.
- issue_ready = !rst && !flush && (IDLE || (DONE && cdb_ready)). Accept = issue_valid && issue_ready.
- On accept: latch funct3, rob_idx, pd. Signedness: A signed for 000/001/010; B signed for 000/001.
- mult_a = |A| if A is signed and negative, else A; same rule for B. 0x80000000 gives magnitude 0x80000000.
- neg flag = signA^signB, using only the operands treated as signed. Then go to BUSY, cnt=0.
- BUSY: mult_a/mult_b held constant; cnt increments each cycle. In the cycle with cnt==MUL_LATENCY, capture r = neg ? (~mult_p+1) : mult_p (64-bit). cdb_data = funct3==000 ? r[31:0] : r[63:32]. Go to DONE.
- Latency: issue accepted in cycle t -> cdb_valid first high in cycle t+MUL_LATENCY+2 (t+16 at default).
- DONE: cdb_valid=1. cdb_* stay stable until cdb_ready. On cdb_ready: go to IDLE, or to BUSY if a new op is accepted the same cycle (back-to-back, no bubble).
- funct3 values 1xx are never issued to this unit; their behaviour is undefined and is not checked.
- flush, any state: next state IDLE, cdb_valid 0 next cycle, in-flight op dropped. flush has priority over cdb_ready and issue. issue_ready is 0 in the flush cycle.
- Only one op is in flight at a time; multiplier pipeline registers are not tracked.

Optional Feature:
MUL_ZERO_BYPASS_EN defined: on accept, if issue_rs1_v==0 or issue_rs2_v==0, skip BUSY. The unit goes straight to DONE with cdb_data=0, so cdb_valid is high in cycle t+1; mult_a/mult_b are not updated.
Not defined: zero operands take the full MUL_LATENCY path, same as any other op.

Test Plan:
1. MUL rs1=0x00000007 rs2=0xFFFFFFFD rob=3 pd=9 issued cycle 0 -> cdb_valid cycle 16, data 0xFFFFFFEB, rob 3, pd 9.
2. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
3. cdb_ready=0 for 5 cycles in DONE -> cdb_valid/cdb_data stable, issue_ready 0. Grant with new issue in the same cycle -> second result valid 16 cycles later.
4. flush at BUSY cnt=5 -> no cdb_valid for that op; issue_ready 1 the next cycle; following MUL 6*7 returns 0x0000002A.
5. rst asserted mid-BUSY -> all outputs 0, issue_ready 0 during rst, 1 after. No stale result.
6. MUL 0*0x12345678 -> with MUL_ZERO_BYPASS_EN: cdb_valid cycle 1, data 0. Without: cdb_valid cycle 16, data 0.

Source files
------------

// File: rtl/mul_fu_ctrl.sv
// Multiply functional-unit controller for RV32M MUL/MULH/MULHSU/MULHU in front of an unsigned pipelined multiplier.
// Optional feature macro: MUL_ZERO_BYPASS_EN (a zero operand completes without using the multiplier).
module mul_fu_ctrl #(
    parameter int MUL_LATENCY = 14,
    parameter int ROB_IDX_W   = 5,
    parameter int PREG_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [2:0]           issue_funct3,
    input  logic [31:0]          issue_rs1_v,
    input  logic [31:0]          issue_rs2_v,
    input  logic [ROB_IDX_W-1:0] issue_rob_idx,
    input  logic [PREG_W-1:0]    issue_pd,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    input  logic [63:0]          mult_p,
    output logic                 cdb_valid,
    input  logic                 cdb_ready,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [PREG_W-1:0]    cdb_pd,
    output logic [31:0]          cdb_data
);

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          mult_a_q, mult_a_d;
    logic [31:0]          mult_b_q, mult_b_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [ROB_IDX_W-1:0] rob_q, rob_d;
    logic [PREG_W-1:0]    pd_q, pd_d;
    logic                 neg_q, neg_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [PREG_W-1:0]    cdb_pd_q, cdb_pd_d;
    logic [31:0]          cdb_data_q, cdb_data_d;

    logic        accept_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        zero_s;
    logic [63:0] result_s;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Handshake, operand sign decode and signed result reconstruction
    always_comb begin
        issue_ready = !rst && !flush &&
                      ((state_q == IDLE) || ((state_q == DONE) && cdb_ready));
        accept_s    = issue_valid && issue_ready;
        // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH
        a_neg_s     = (issue_funct3 != 3'b011) && issue_rs1_v[31];
        b_neg_s     = ((issue_funct3 == 3'b000) || (issue_funct3 == 3'b001)) && issue_rs2_v[31];
`ifdef MUL_ZERO_BYPASS_EN
        zero_s      = (issue_rs1_v == 32'd0) || (issue_rs2_v == 32'd0);
`else
        zero_s      = 1'b0;
`endif
        result_s    = neg_q ? (~mult_p + 64'd1) : mult_p;
    end

    // Next-state logic: flush overrides everything, a new accept overrides the DONE->IDLE step
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        funct3_d      = funct3_q;
        rob_d         = rob_q;
        pd_d          = pd_q;
        neg_d         = neg_q;
        cdb_valid_d   = cdb_valid_q;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_pd_d      = cdb_pd_q;
        cdb_data_d    = cdb_data_q;

        if (flush) begin
            state_d     = IDLE;
            cdb_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                BUSY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d       = DONE;
                        cdb_valid_d   = 1'b1;
                        cdb_rob_idx_d = rob_q;
                        cdb_pd_d      = pd_q;
                        cdb_data_d    = (funct3_q == 3'b000) ? result_s[31:0] : result_s[63:32];
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    if (cdb_ready) begin
                        state_d     = IDLE;
                        cdb_valid_d = 1'b0;
                    end else begin
                        state_d     = DONE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cdb_valid_d = 1'b0;
                end
            endcase
        end

        if (accept_s) begin
            funct3_d = issue_funct3;
            rob_d    = issue_rob_idx;
            pd_d     = issue_pd;
            neg_d    = a_neg_s ^ b_neg_s;
            if (zero_s) begin
                state_d       = DONE;
                cdb_valid_d   = 1'b1;
                cdb_rob_idx_d = issue_rob_idx;
                cdb_pd_d      = issue_pd;
                cdb_data_d    = 32'd0;
            end else begin
                state_d  = BUSY;
                cnt_d    = '0;
                mult_a_d = magnitude(issue_rs1_v, a_neg_s);
                mult_b_d = magnitude(issue_rs2_v, b_neg_s);
            end
        end else begin
            funct3_d = funct3_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mult_a_q      <= 32'd0;
            mult_b_q      <= 32'd0;
            funct3_q      <= 3'd0;
            rob_q         <= '0;
            pd_q          <= '0;
            neg_q         <= 1'b0;
            cdb_valid_q   <= 1'b0;
            cdb_rob_idx_q <= '0;
            cdb_pd_q      <= '0;
            cdb_data_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            funct3_q      <= funct3_d;
            rob_q         <= rob_d;
            pd_q          <= pd_d;
            neg_q         <= neg_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_pd_q      <= cdb_pd_d;
            cdb_data_q    <= cdb_data_d;
        end
    end

    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_pd      = cdb_pd_q;
    assign cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// Self-checking bench for mul_fu_ctrl with a behavioural pipelined multiplier and a signed-arithmetic reference model.
module tb_mul_fu_ctrl;

    localparam int MUL_LATENCY = 14;
    localparam int ROB_IDX_W   = 5;
    localparam int PREG_W      = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 issue_valid = 1'b0;
    logic                 issue_ready;
    logic [2:0]           issue_funct3 = 3'd0;
    logic [31:0]          issue_rs1_v = 32'd0;
    logic [31:0]          issue_rs2_v = 32'd0;
    logic [ROB_IDX_W-1:0] issue_rob_idx = '0;
    logic [PREG_W-1:0]    issue_pd = '0;
    logic [31:0]          mult_a;
    logic [31:0]          mult_b;
    logic [63:0]          mult_p;
    logic                 cdb_valid;
    logic                 cdb_ready = 1'b0;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [PREG_W-1:0]    cdb_pd;
    logic [31:0]          cdb_data;

    int checks = 0;
    int errors = 0;

    mul_fu_ctrl #(.MUL_LATENCY(MUL_LATENCY), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_funct3(issue_funct3),
        .issue_rs1_v(issue_rs1_v), .issue_rs2_v(issue_rs2_v),
        .issue_rob_idx(issue_rob_idx), .issue_pd(issue_pd),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_rob_idx(cdb_rob_idx), .cdb_pd(cdb_pd), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    // Unsigned multiplier: product of operands seen at an edge appears MUL_LATENCY cycles after they were presented
    logic [63:0] pipe [MUL_LATENCY];
    initial begin
        for (int i = 0; i < MUL_LATENCY; i++) pipe[i] = 64'd0;
    end
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mult_a} * {32'd0, mult_b};
        for (int i = 1; i < MUL_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign mult_p = pipe[MUL_LATENCY-1];

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = (f3 == 3'd3) ? longint'({32'd0, a}) : longint'($signed(a));
        sb = (f3 == 3'd0 || f3 == 3'd1) ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic drive_issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [ROB_IDX_W-1:0] rob, input logic [PREG_W-1:0] pd);
        int n;
        n = 0;
        @(posedge clk); #1;
        issue_valid = 1'b1; issue_funct3 = f3; issue_rs1_v = a; issue_rs2_v = b;
        issue_rob_idx = rob; issue_pd = pd;
        @(negedge clk);
        while (!issue_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!issue_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: issue_ready=%b required 1", issue_ready);
        end
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic wait_cdb(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cdb_valid && lat < 200);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [ROB_IDX_W-1:0] rob, input logic [PREG_W-1:0] pd,
                          input logic [31:0] exp, input int hold, input string name);
        int lat, exp_lat;
        logic [31:0] held;
        exp_lat = MUL_LATENCY + 2;
`ifdef MUL_ZERO_BYPASS_EN
        if (a == 32'd0 || b == 32'd0) exp_lat = 1;
`endif
        drive_issue(f3, a, b, rob, pd);
        wait_cdb(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (cdb_data !== exp) begin
            errors++; $display("FAIL %s data: got %h required %h", name, cdb_data, exp);
        end
        checks++;
        if (cdb_rob_idx !== rob || cdb_pd !== pd) begin
            errors++; $display("FAIL %s tags: got rob=%0d pd=%0d required rob=%0d pd=%0d",
                               name, cdb_rob_idx, cdb_pd, rob, pd);
        end
        held = cdb_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (cdb_valid !== 1'b1 || cdb_data !== held || issue_ready !== 1'b0) begin
                errors++; $display("FAIL %s hold: got valid=%b data=%h ready=%b required 1 %h 0",
                                   name, cdb_valid, cdb_data, issue_ready, held);
            end
        end
        cdb_ready = 1'b1;
        @(posedge clk); #1;
        cdb_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (cdb_valid !== 1'b0 || mult_a !== 32'd0 || mult_b !== 32'd0 || cdb_data !== 32'd0 ||
            cdb_rob_idx !== '0 || cdb_pd !== '0 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid=%b a=%h b=%h data=%h rob=%0d pd=%0d ready=%b required all 0",
                     name, cdb_valid, mult_a, mult_b, cdb_data, cdb_rob_idx, cdb_pd, issue_ready);
        end
    endtask

    task automatic watch_no_cdb(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cdb_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL %s: cdb_valid high %0d cycles, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b required 1", issue_ready);
        end
    endtask

    task automatic test_directed();
        run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd3, 6'd9, 32'hFFFFFFEB, 0, "mul_7_m3");
        run_op(3'b001, 32'h80000000, 32'h80000000, 5'd4, 6'd10, 32'h40000000, 0, "mulh_min");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 6'd11, 32'hFFFFFFFE, 0, "mulhu_max");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 6'd12, 32'hFFFFFFFF, 0, "mulhsu_m1");
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 6'd13, 32'h00000000, 0, "mulh_m1");
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp2;
        exp2 = ref_mul(3'b000, 32'hFFFF1234, 32'h00000321);
        run_op(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd20, 6'd40,
               ref_mul(3'b011, 32'h12345678, 32'h9ABCDEF0), 5, "backpressure");
        drive_issue(3'b001, 32'h00000123, 32'h00000456, 5'd21, 6'd41);
        wait_cdb(lat);
        repeat (2) @(negedge clk);
        cdb_ready = 1'b1;
        issue_valid = 1'b1; issue_funct3 = 3'b000; issue_rs1_v = 32'hFFFF1234;
        issue_rs2_v = 32'h00000321; issue_rob_idx = 5'd22; issue_pd = 6'd42;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b required 1", issue_ready);
        end
        @(posedge clk); #1;
        cdb_ready = 1'b0; issue_valid = 1'b0;
        wait_cdb(lat);
        checks++;
        if (lat !== MUL_LATENCY + 2) begin
            errors++; $display("FAIL b2b_latency: got %0d required %0d", lat, MUL_LATENCY + 2);
        end
        checks++;
        if (cdb_data !== exp2 || cdb_rob_idx !== 5'd22 || cdb_pd !== 6'd42) begin
            errors++; $display("FAIL b2b_result: got %h rob=%0d pd=%0d required %h rob=22 pd=42",
                               cdb_data, cdb_rob_idx, cdb_pd, exp2);
        end
        cdb_ready = 1'b1;
        @(posedge clk); #1;
        cdb_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive_issue(3'b000, 32'h0BADF00D, 32'h00001111, 5'd8, 6'd14);
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        cdb_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b required 0", issue_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        cdb_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1 || cdb_valid !== 1'b0) begin
            errors++; $display("FAIL flush_after: got ready=%b valid=%b required 1 0", issue_ready, cdb_valid);
        end
        watch_no_cdb(30, "flush_dropped");
        run_op(3'b000, 32'd6, 32'd7, 5'd9, 6'd15, 32'h0000002A, 0, "flush_then_mul");
    endtask

    task automatic test_reset_mid();
        drive_issue(3'b001, 32'h87654321, 32'h7FFFFFFF, 5'd10, 6'd16);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready: got %b required 0", issue_ready);
        end
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_mid_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_release: got %b required 1", issue_ready);
        end
        watch_no_cdb(30, "rst_no_stale");
    endtask

    task automatic test_zero();
        logic [31:0] a_before;
        a_before = mult_a;
        run_op(3'b000, 32'd0, 32'h12345678, 5'd11, 6'd17, 32'd0, 0, "zero_mul");
`ifdef MUL_ZERO_BYPASS_EN
        checks++;
        if (mult_a !== a_before) begin
            errors++; $display("FAIL zero_mult_a: got %h required %h", mult_a, a_before);
        end
`endif
        run_op(3'b001, 32'hFFFFFFFF, 32'd0, 5'd12, 6'd18, 32'd0, 1, "zero_mulh");
    endtask

    task automatic test_random();
        logic [31:0] ops [2];
        logic [2:0] f3;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 4))
                    0: ops[k] = 32'h80000000;
                    1: ops[k] = 32'hFFFFFFFF;
                    2: ops[k] = 32'($urandom_range(0, 20)) - 32'd10;
                    default: ops[k] = $urandom;
                endcase
            end
            f3 = 3'($urandom_range(0, 3));
            run_op(f3, ops[0], ops[1], 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                   ref_mul(f3, ops[0], ops[1]), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
